// File: rtl/regfile_pkg.sv
// Shared register-file definitions. The register file and the debug readers
// that walk it use these.
package regfile_pkg;

    localparam int          REG_COUNT  = 16;
    localparam int          REG_ADDR_W = 4;
    localparam logic [3:0]  PC_REG     = 4'd15;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        SEND,
        DONE
    } dump_state_t;

endpackage

// File: rtl/regfile_dump_reader.sv
// Walks a range of register-file entries over one read port and streams each
// captured word out through a valid/ready handshake.
//
// state | meaning
// IDLE  | parked on FIRST_REG, waiting for start
// READ  | one cycle: capture rf_data for rf_addr into the output word
// SEND  | word held stable until the consumer accepts it
// DONE  | one-cycle done pulse, then back to IDLE
module regfile_dump_reader
    import regfile_pkg::*;
#(
    parameter int N         = 32,
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 15
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  abort_i,
    output logic [REG_ADDR_W-1:0] rf_addr_o,
    input  logic [N-1:0]          rf_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [N-1:0]          out_data_o,
    output logic [REG_ADDR_W-1:0] out_index_o,
    output logic                  out_last_o,
    output logic                  busy_o,
    output logic                  done_o
);

    if (FIRST_REG < 0 || FIRST_REG > LAST_REG || LAST_REG > REG_COUNT - 1) begin : g_param_check
        $error("regfile_dump_reader: FIRST_REG/LAST_REG outside 0 <= FIRST_REG <= LAST_REG <= 15");
    end

    localparam logic [REG_ADDR_W-1:0] FIRST_A = REG_ADDR_W'(FIRST_REG);
    localparam logic [REG_ADDR_W-1:0] LAST_A  = REG_ADDR_W'(LAST_REG);

    dump_state_t           state_q;
    logic [REG_ADDR_W-1:0] addr_q;
    logic                  valid_q;
    logic [N-1:0]          data_q;
    logic [REG_ADDR_W-1:0] index_q;
    logic                  last_q;
    logic                  busy_q;
    logic                  done_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= FIRST_A;
            valid_q <= 1'b0;
            data_q  <= '0;
            index_q <= '0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    addr_q <= FIRST_A;
                    if (start_i && !abort_i) begin
                        state_q <= READ;
                        busy_q  <= 1'b1;
                    end
                end
                READ: begin
                    if (abort_i) begin
                        state_q <= IDLE;
                        addr_q  <= FIRST_A;
                        busy_q  <= 1'b0;
                    end else begin
                        data_q  <= rf_data_i;
                        index_q <= addr_q;
                        last_q  <= (addr_q == LAST_A);
                        valid_q <= 1'b1;
                        state_q <= SEND;
                    end
                end
                SEND: begin
                    if (abort_i) begin
                        state_q <= IDLE;
                        addr_q  <= FIRST_A;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (valid_q && out_ready_i) begin
                        valid_q <= 1'b0;
                        // The last word never advances the address, so it stops at LAST_REG.
                        if (last_q) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            addr_q  <= addr_q + REG_ADDR_W'(1);
                            state_q <= READ;
                        end
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    addr_q  <= FIRST_A;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rf_addr_o   = addr_q;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;
    assign out_index_o = index_q;
    assign out_last_o  = last_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: three instances (full range, 13..15, single
// register 5) sharing one modelled register file.
module tb_regfile_dump_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start_s [3];
    logic        abort_s [3];
    logic        ready_s [3];
    logic [3:0]  addr_s  [3];
    logic [31:0] rfd_s   [3];
    logic        valid_s [3];
    logic [31:0] data_s  [3];
    logic [3:0]  idx_s   [3];
    logic        last_s  [3];
    logic        busy_s  [3];
    logic        done_s  [3];

    logic [31:0] regs [16];

    assign rfd_s[0] = regs[addr_s[0]];
    assign rfd_s[1] = regs[addr_s[1]];
    assign rfd_s[2] = regs[addr_s[2]];

    regfile_dump_reader #(.N(32), .FIRST_REG(0), .LAST_REG(15)) dut0 (
        .clk_i(clk), .rst_i(rst), .start_i(start_s[0]), .abort_i(abort_s[0]),
        .rf_addr_o(addr_s[0]), .rf_data_i(rfd_s[0]), .out_valid_o(valid_s[0]),
        .out_ready_i(ready_s[0]), .out_data_o(data_s[0]), .out_index_o(idx_s[0]),
        .out_last_o(last_s[0]), .busy_o(busy_s[0]), .done_o(done_s[0]));

    regfile_dump_reader #(.N(32), .FIRST_REG(13), .LAST_REG(15)) dut1 (
        .clk_i(clk), .rst_i(rst), .start_i(start_s[1]), .abort_i(abort_s[1]),
        .rf_addr_o(addr_s[1]), .rf_data_i(rfd_s[1]), .out_valid_o(valid_s[1]),
        .out_ready_i(ready_s[1]), .out_data_o(data_s[1]), .out_index_o(idx_s[1]),
        .out_last_o(last_s[1]), .busy_o(busy_s[1]), .done_o(done_s[1]));

    regfile_dump_reader #(.N(32), .FIRST_REG(5), .LAST_REG(5)) dut2 (
        .clk_i(clk), .rst_i(rst), .start_i(start_s[2]), .abort_i(abort_s[2]),
        .rf_addr_o(addr_s[2]), .rf_data_i(rfd_s[2]), .out_valid_o(valid_s[2]),
        .out_ready_i(ready_s[2]), .out_data_o(data_s[2]), .out_index_o(idx_s[2]),
        .out_last_o(last_s[2]), .busy_o(busy_s[2]), .done_o(done_s[2]));

    typedef struct {
        int          idx;
        logic [31:0] val;
    } word_t;

    // exp_done: edges counted from the cycle in which start is driven.
    typedef struct {
        int dut;
        int stall_idx;
        int stall_len;
        int exp_done;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    function automatic int first_of(input int d);
        return (d == 0) ? 0 : (d == 1) ? 13 : 5;
    endfunction

    function automatic int last_of(input int d);
        return (d == 2) ? 5 : 15;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete dump on instance d. A write of wr_val into wr_idx is applied
    // during the first READ cycle; the expected words are the register values
    // as they stand when each word's READ cycle happens.
    task automatic run_dump(input int d, input int stall_idx, input int stall_len,
                            input bit rnd, input int exp_done, input int wr_idx,
                            input logic [31:0] wr_val);
        word_t       exp_q [$];
        word_t       w;
        int          n = 0, stall_cnt = 0, words = 0, first_valid = -1, done_n = -1;
        bit          hs, pv, pr;
        logic [31:0] pdata;
        logic [3:0]  pidx;
        start_s[d] = 1'b1;
        ready_s[d] = 1'b0;
        tick();
        n = 1;
        start_s[d] = 1'b0;
        chk("busy_after_start", 32'(busy_s[d]), 32'd1);
        if (wr_idx >= 0) regs[wr_idx] = wr_val;
        for (int i = first_of(d); i <= last_of(d); i++) begin
            w.idx = i;
            w.val = regs[i];
            exp_q.push_back(w);
        end
        pv = 1'b0;
        pr = 1'b0;
        pdata = '0;
        pidx = '0;
        while (n < 600 && done_n < 0) begin
            if (valid_s[d] && first_valid < 0) begin
                first_valid = n;
                chk("first_valid_latency", 32'(n), 32'd2);
            end
            if (pv && !pr) begin
                chk("hold_valid", 32'(valid_s[d]), 32'd1);
                chk("hold_data", data_s[d], pdata);
                chk("hold_index", 32'(idx_s[d]), 32'(pidx));
            end
            if (rnd) begin
                ready_s[d] = ($urandom_range(0, 9) < 6);
            end else if (valid_s[d] && int'(idx_s[d]) == stall_idx && stall_cnt < stall_len) begin
                ready_s[d] = 1'b0;
                stall_cnt++;
                chk("stall_rf_addr", 32'(addr_s[d]), 32'(stall_idx));
            end else begin
                ready_s[d] = 1'b1;
            end
            hs = valid_s[d] && ready_s[d];
            if (hs) begin
                words++;
                if (exp_q.size() == 0) begin
                    chk("extra_word", 32'(idx_s[d]), 32'hFFFF_FFFF);
                end else begin
                    w = exp_q.pop_front();
                    chk("word_index", 32'(idx_s[d]), 32'(w.idx));
                    chk("word_data", data_s[d], w.val);
                    chk("word_last", 32'(last_s[d]), 32'(w.idx == last_of(d)));
                end
            end
            pv = valid_s[d];
            pr = ready_s[d];
            pdata = data_s[d];
            pidx = idx_s[d];
            tick();
            n++;
            if (done_s[d]) done_n = n;
        end
        ready_s[d] = 1'b0;
        chk("done_seen", 32'(done_n > 0), 32'd1);
        chk("word_count", 32'(words), 32'(last_of(d) - first_of(d) + 1));
        if (exp_done > 0) chk("done_latency", 32'(done_n), 32'(exp_done));
        tick();
        chk("done_one_cycle", 32'(done_s[d]), 32'd0);
        chk("busy_cleared", 32'(busy_s[d]), 32'd0);
        chk("idle_rf_addr", 32'(addr_s[d]), 32'(first_of(d)));
    endtask

    task automatic chk_reset_outputs(input int d, input string tag);
        chk({tag, "_valid"}, 32'(valid_s[d]), 32'd0);
        chk({tag, "_data"}, data_s[d], 32'd0);
        chk({tag, "_index"}, 32'(idx_s[d]), 32'd0);
        chk({tag, "_last"}, 32'(last_s[d]), 32'd0);
        chk({tag, "_busy"}, 32'(busy_s[d]), 32'd0);
        chk({tag, "_done"}, 32'(done_s[d]), 32'd0);
        chk({tag, "_rf_addr"}, 32'(addr_s[d]), 32'(first_of(d)));
    endtask

    initial begin
        vec_t vecs [5];
        int   cnt, guard;

        vecs[0] = '{dut: 0, stall_idx: -1, stall_len: 0, exp_done: 33};
        vecs[1] = '{dut: 0, stall_idx: 3,  stall_len: 5, exp_done: 38};
        vecs[2] = '{dut: 0, stall_idx: 15, stall_len: 2, exp_done: 35};
        vecs[3] = '{dut: 0, stall_idx: 0,  stall_len: 1, exp_done: 34};
        vecs[4] = '{dut: 2, stall_idx: -1, stall_len: 0, exp_done: 3};

        for (int d = 0; d < 3; d++) begin
            start_s[d] = 1'b0;
            abort_s[d] = 1'b0;
            ready_s[d] = 1'b0;
        end
        for (int i = 0; i < 16; i++) regs[i] = 32'hA000_0000 + 32'(i);

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int d = 0; d < 3; d++) chk_reset_outputs(d, "reset");
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            ready_s[0] = 1'b1;
            tick();
            if (valid_s[0] || busy_s[0]) cnt++;
        end
        ready_s[0] = 1'b0;
        chk("idle_no_valid", 32'(cnt), 32'd0);

        foreach (vecs[v])
            run_dump(vecs[v].dut, vecs[v].stall_idx, vecs[v].stall_len, 1'b0,
                     vecs[v].exp_done, -1, 32'd0);

        // Restricted range with r14 rewritten during the READ of r13.
        chk("r14_before", regs[14], 32'hA000_000E);
        run_dump(1, -1, 0, 1'b0, 7, 14, 32'h0000_1234);
        chk("r14_after", regs[14], 32'h0000_1234);

        // Abort while index 7 is waiting in SEND.
        start_s[0] = 1'b1;
        tick();
        start_s[0] = 1'b0;
        guard = 0;
        while (!(valid_s[0] && idx_s[0] == 4'd7) && guard < 100) begin
            ready_s[0] = valid_s[0];
            tick();
            guard++;
        end
        chk("abort_reached_7", 32'(guard < 100), 32'd1);
        ready_s[0] = 1'b0;
        abort_s[0] = 1'b1;
        tick();
        abort_s[0] = 1'b0;
        chk("abort_valid", 32'(valid_s[0]), 32'd0);
        chk("abort_busy", 32'(busy_s[0]), 32'd0);
        chk("abort_rf_addr", 32'(addr_s[0]), 32'd0);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (done_s[0] || valid_s[0]) cnt++;
            tick();
        end
        chk("abort_no_done", 32'(cnt), 32'd0);

        // Start and abort together in IDLE: abort wins.
        start_s[0] = 1'b1;
        abort_s[0] = 1'b1;
        tick();
        start_s[0] = 1'b0;
        abort_s[0] = 1'b0;
        tick();
        chk("start_abort_idle", 32'(busy_s[0] | valid_s[0]), 32'd0);

        // Restart after abort begins at index 0; extra start while busy is ignored.
        start_s[0] = 1'b1;
        tick();
        start_s[0] = 1'b0;
        tick();
        chk("restart_index", 32'(idx_s[0]), 32'd0);
        chk("restart_valid", 32'(valid_s[0]), 32'd1);
        start_s[0] = 1'b1;
        ready_s[0] = 1'b1;
        tick();
        start_s[0] = 1'b0;
        ready_s[0] = 1'b0;
        tick();
        chk("busy_start_ignored", 32'(idx_s[0]), 32'd1);
        guard = 0;
        while (!(valid_s[0] && idx_s[0] == 4'd5) && guard < 100) begin
            ready_s[0] = valid_s[0];
            tick();
            guard++;
        end
        ready_s[0] = 1'b0;
        chk("rst_reached_5", 32'(guard < 100), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_outputs(0, "rst_in_send");

        // Randomized contents and randomized backpressure on every instance.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 16; i++) regs[i] = $urandom;
            run_dump(r % 3, -1, 0, 1'b1, 0, -1, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
